clp_scheduler: RTL and testbench
================================

CLP_SCHEDULER -- requirements
Module: clp_scheduler

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing one CLP runtime counter.
REQ-002 SHALL have parameter TIME_W, default 16: width of each requested work time.
REQ-003 SHALL have parameter CNT_MAX, default 4095: largest work time the CLP counter can reach (12-bit counter).
REQ-004 SHALL have parameter START_TMO, default 4: cycles allowed for clp_state to rise after launch.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req  input  NREQ  per-requester request level; requester holds it until its done pulse.
REQ-008 SHALL have port work_time  input  NREQ*TIME_W  flattened work times; requester i uses bits [i*TIME_W +: TIME_W].
REQ-009 SHALL have port grant  output  NREQ  one-hot owner of the CLP; all zero when idle.
REQ-010 SHALL have port done  output  NREQ  one-cycle completion pulse to the owner.
REQ-011 SHALL have port err  output  1  one-cycle pulse, coincident with done, when the launch timed out.
REQ-012 SHALL have port busy  output  1  high whenever the FSM is not IDLE.
REQ-013 SHALL have port clp_enable  output  1  one-cycle start pulse to the CLP runtime counter.
REQ-014 SHALL have port clp_work_time  output  TIME_W  work time for the CLP runtime counter, stable for the whole operation.
REQ-015 SHALL have port clp_state  input  1  CLP runtime counter running flag.
REQ-016 SHALL have port run_cycles  output  TIME_W  cycles clp_state was high in the last completed operation, saturating.

Function
REQ-017 SHALL implement FSM states IDLE, LAUNCH, WAIT_START, RUN, DONE.
REQ-018 IDLE: when req is nonzero, SHALL select the requester by round-robin starting at pointer rr_ptr, latch its index and work time, and go to LAUNCH next cycle.
REQ-019 SHALL clamp the latched work time to CNT_MAX when the requested value exceeds CNT_MAX; values 0..CNT_MAX SHALL pass unchanged.
REQ-020 LAUNCH: SHALL assert clp_enable for exactly this one cycle, then go to WAIT_START.
REQ-021 WAIT_START: if clp_state=1, SHALL go to RUN; after START_TMO cycles with clp_state=0, SHALL go to DONE with the timeout flag set.
REQ-022 RUN: SHALL increment the run counter each cycle, saturating at 2^TIME_W-1; on clp_state=0, SHALL go to DONE.
REQ-023 DONE: SHALL pulse done[idx] and, if timed out, err; SHALL load run_cycles from the run counter (0 on timeout); SHALL set rr_ptr=(idx+1) mod NREQ; SHALL go to IDLE.
REQ-024 grant[idx] SHALL be high from LAUNCH through DONE inclusive; clp_work_time SHALL hold the latched value from LAUNCH through DONE.
REQ-025 A requester deasserting req mid-operation SHALL be ignored: the operation completes and done still pulses.
REQ-026 req and work_time changes SHALL be sampled only in IDLE.
REQ-027 Minimum occupancy SHALL be 4 cycles (LAUNCH, WAIT_START, RUN, DONE); back-to-back operations SHALL have one IDLE cycle between DONE and the next LAUNCH.
REQ-028 With simultaneous requests, the lowest index at or after rr_ptr SHALL win; a requester SHALL wait at most NREQ-1 operations.

Reset
REQ-029 While rst=0, SHALL hold: state=IDLE, grant=0, done=0, err=0, busy=0, clp_enable=0, clp_work_time=0, run_cycles=0, rr_ptr=0, counters=0.
REQ-030 Reset mid-operation SHALL abort without a done pulse; after release, pending req SHALL be rearbitrated from rr_ptr=0.

Verification
REQ-031 Single request: req=0001, work_time[0]=10, model CLP -> clp_enable one pulse; clp_work_time=10; grant=0001 until done[0]; run_cycles=11.
REQ-032 Contention: req=1111 held, rr_ptr=0 -> grants in order 0,1,2,3,0; each done pulses once per operation; grant is always one-hot.
REQ-033 Clamp: work_time[2]=5000 -> clp_work_time=4095; model CLP finishes; done[2] pulses; run_cycles=4096.
REQ-034 Timeout: clp_state tied 0, req=0010 -> done[1] and err pulse together 4 cycles after WAIT_START entry; run_cycles=0; FSM returns to IDLE.
REQ-035 Reset mid-RUN: assert rst=0 during RUN -> all outputs zero immediately (asynchronously); no done pulse; with req=1000 held after release -> grant=1000.
REQ-036 Zero time and early drop: work_time=0 -> op completes, done pulses, run_cycles=1; req dropped in RUN -> done still pulses.

Source files
------------

// File: rtl/clp_scheduler.sv
// Round-robin scheduler that shares one CLP runtime counter among NREQ requesters,
// launching one operation at a time and reporting its measured run length.
module clp_scheduler #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned TIME_W    = 16,
    parameter int unsigned CNT_MAX   = 4095,
    parameter int unsigned START_TMO = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*TIME_W-1:0]   work_time,
    output logic [NREQ-1:0]          grant,
    output logic [NREQ-1:0]          done,
    output logic                     err,
    output logic                     busy,
    output logic                     clp_enable,
    output logic [TIME_W-1:0]        clp_work_time,
    input  logic                     clp_state,
    output logic [TIME_W-1:0]        run_cycles
);

    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned TmoW = (START_TMO > 1) ? $clog2(START_TMO) : 1;
    localparam logic [NREQ-1:0] Lsb = NREQ'(1);

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWaitStart,
        StRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [IdxW-1:0]   rr_q, rr_d;
    logic [TIME_W-1:0] work_q, work_d;
    logic [TIME_W-1:0] run_cnt_q, run_cnt_d;
    logic [TmoW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic              timeout_q, timeout_d;
    logic [TIME_W-1:0] run_cycles_q, run_cycles_d;

    logic              pick_vld;
    logic [IdxW-1:0]   pick_idx;
    logic [IdxW-1:0]   cand;
    logic [TIME_W-1:0] wt_raw;
    logic [TIME_W-1:0] wt_clamped;

    // First requester at or after rr_q, wrapping around.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IdxW'((32'(rr_q) + k) % NREQ);
            if (!pick_vld && req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_comb begin
        wt_raw     = work_time[pick_idx*TIME_W +: TIME_W];
        wt_clamped = (32'(wt_raw) > CNT_MAX) ? TIME_W'(CNT_MAX) : wt_raw;
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        rr_d         = rr_q;
        work_d       = work_q;
        run_cnt_d    = run_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        timeout_d    = timeout_q;
        run_cycles_d = run_cycles_q;
        unique case (state_q)
            StIdle: begin
                if (pick_vld) begin
                    idx_d   = pick_idx;
                    work_d  = wt_clamped;
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
                run_cnt_d = '0;
                tmo_cnt_d = '0;
                timeout_d = 1'b0;
                state_d   = StWaitStart;
            end
            StWaitStart: begin
                // The first high cycle of clp_state is seen here, so it is counted here.
                if (clp_state) begin
                    run_cnt_d = TIME_W'(1);
                    state_d   = StRun;
                end else if (32'(tmo_cnt_q) + 1 >= START_TMO) begin
                    timeout_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (clp_state) begin
                    if (run_cnt_q != {TIME_W{1'b1}}) begin
                        run_cnt_d = run_cnt_q + 1'b1;
                    end
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                run_cycles_d = timeout_q ? '0 : run_cnt_q;
                rr_d         = (32'(idx_q) == NREQ - 1) ? '0 : idx_q + 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            rr_q         <= '0;
            work_q       <= '0;
            run_cnt_q    <= '0;
            tmo_cnt_q    <= '0;
            timeout_q    <= 1'b0;
            run_cycles_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            rr_q         <= rr_d;
            work_q       <= work_d;
            run_cnt_q    <= run_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            timeout_q    <= timeout_d;
            run_cycles_q <= run_cycles_d;
        end
    end

    always_comb begin
        busy          = (state_q != StIdle);
        clp_enable    = (state_q == StLaunch);
        grant         = busy ? (Lsb << idx_q) : '0;
        done          = (state_q == StDone) ? (Lsb << idx_q) : '0;
        err           = (state_q == StDone) && timeout_q;
        clp_work_time = work_q;
        run_cycles    = run_cycles_q;
    end

endmodule

// File: tb/tb_clp_scheduler.sv
// Bench for clp_scheduler: directed scenarios plus randomized operations checked against
// a behavioural CLP model and an arbitration/timing reference model.
module tb_clp_scheduler;

    localparam int NREQ      = 4;
    localparam int TIME_W    = 16;
    localparam int CNT_MAX   = 4095;
    localparam int START_TMO = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req;
    logic [NREQ*TIME_W-1:0] work_time;
    logic [NREQ-1:0]        grant;
    logic [NREQ-1:0]        done;
    logic                   err;
    logic                   busy;
    logic                   clp_enable;
    logic [TIME_W-1:0]      clp_work_time;
    logic                   clp_state;
    logic [TIME_W-1:0]      run_cycles;

    int checks   = 0;
    int failures = 0;
    int m_rr;
    int idx;
    int n;
    logic clp_dead;

    clp_scheduler #(
        .NREQ      (NREQ),
        .TIME_W    (TIME_W),
        .CNT_MAX   (CNT_MAX),
        .START_TMO (START_TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .work_time     (work_time),
        .grant         (grant),
        .done          (done),
        .err           (err),
        .busy          (busy),
        .clp_enable    (clp_enable),
        .clp_work_time (clp_work_time),
        .clp_state     (clp_state),
        .run_cycles    (run_cycles)
    );

    always #5 clk = ~clk;

    // CLP runtime counter: runs for work_time+1 cycles after a start pulse.
    logic clp_run;
    int   clp_left;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            clp_run  <= 1'b0;
            clp_left <= 0;
        end else if (clp_enable && !clp_dead) begin
            clp_run  <= 1'b1;
            clp_left <= int'(clp_work_time);
        end else if (clp_run) begin
            if (clp_left == 0) clp_run <= 1'b0;
            else clp_left <= clp_left - 1;
        end
    end
    assign clp_state = clp_run;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model_pick(input logic [NREQ-1:0] r, input int rr);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(rr + k) % NREQ]) return (rr + k) % NREQ;
        end
        return 0;
    endfunction

    function automatic int model_clamp(input int wt);
        return (wt > CNT_MAX) ? CNT_MAX : wt;
    endfunction

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
            check("done_in_grant", 32'(done & ~grant), 32'd0);
        end
    end

    // Called at a negedge while the DUT is idle; predicts and checks one whole operation.
    task automatic do_op(input int drop_at, output int got_idx);
        int   exp_idx, exp_wt, exp_rc, exp_lat, cnt;
        logic exp_err, seen;
        exp_idx = model_pick(req, m_rr);
        exp_wt  = model_clamp(int'(work_time[exp_idx*TIME_W +: TIME_W]));
        exp_err = clp_dead;
        exp_rc  = exp_err ? 0 : ((exp_wt + 1 > 65535) ? 65535 : exp_wt + 1);
        exp_lat = exp_err ? START_TMO + 1 : exp_wt + 3;

        cnt = 0;
        seen = 1'b0;
        while (!seen && cnt < 8) begin
            @(negedge clk);
            cnt++;
            seen = clp_enable;
        end
        check("launch_gap", cnt, 1);
        check("launch_grant", 32'(grant), 32'(1) << exp_idx);
        check("launch_work_time", 32'(clp_work_time), exp_wt);
        check("launch_busy", 32'(busy), 32'd1);

        cnt = 0;
        seen = 1'b0;
        while (!seen && cnt < exp_lat + 8) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) check("enable_one_cycle", 32'(clp_enable), 32'd0);
            if (cnt == 2) work_time = {$urandom, $urandom} & {NREQ{16'h001f}};
            if (cnt == drop_at) req = '0;
            seen = (done != '0);
            if (!seen) check("work_time_stable", 32'(clp_work_time), exp_wt);
        end
        check("done_latency", cnt, exp_lat);
        check("done_vec", 32'(done), 32'(1) << exp_idx);
        check("err", 32'(err), 32'(exp_err));
        check("done_grant", 32'(grant), 32'(1) << exp_idx);

        @(negedge clk);
        check("run_cycles", 32'(run_cycles), exp_rc);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        m_rr    = (exp_idx + 1) % NREQ;
        got_idx = exp_idx;
    endtask

    initial begin
        rst       = 1'b1;
        req       = '0;
        work_time = '0;
        clp_dead  = 1'b0;
        m_rr      = 0;
        #3 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_enable", 32'(clp_enable), 32'd0);
        check("rst_work_time", 32'(clp_work_time), 32'd0);
        check("rst_run_cycles", 32'(run_cycles), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);

        // Single request.
        work_time[0 +: TIME_W] = 16'd10;
        req = 4'b0001;
        do_op(-1, idx);
        check("single_run_cycles", 32'(run_cycles), 32'd11);
        req = '0;

        // Contention from rr_ptr=0.
        rst = 1'b0;
        @(negedge clk);
        rst  = 1'b1;
        m_rr = 0;
        req  = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            work_time = {$urandom, $urandom} & {NREQ{16'h000f}};
            do_op(-1, idx);
            check("rr_order", idx, i % NREQ);
        end
        req = '0;

        // Clamp.
        work_time = '0;
        work_time[2*TIME_W +: TIME_W] = 16'd5000;
        req = 4'b0100;
        do_op(-1, idx);
        check("clamp_run_cycles", 32'(run_cycles), 32'd4096);
        req = '0;

        // Launch timeout.
        clp_dead = 1'b1;
        req = 4'b0010;
        do_op(-1, idx);
        check("tmo_run_cycles", 32'(run_cycles), 32'd0);
        clp_dead = 1'b0;
        req = '0;
        @(negedge clk);
        check("tmo_idle", 32'(busy), 32'd0);

        // Reset in RUN.
        work_time = '0;
        work_time[0 +: TIME_W] = 16'd50;
        req = 4'b0001;
        n = 0;
        while (!clp_enable && n < 8) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        check("mid_run_busy", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_grant", 32'(grant), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_work_time", 32'(clp_work_time), 32'd0);
        check("arst_run_cycles", 32'(run_cycles), 32'd0);
        req = 4'b1000;
        @(negedge clk);
        check("arst_no_done", 32'(done), 32'd0);
        rst  = 1'b1;
        m_rr = 0;
        do_op(-1, idx);
        check("post_rst_winner", idx, 3);
        req = '0;

        // Zero work time.
        work_time = '0;
        req = 4'b0001;
        do_op(-1, idx);
        check("zero_run_cycles", 32'(run_cycles), 32'd1);

        // Request dropped while running.
        work_time[2*TIME_W +: TIME_W] = 16'd30;
        req = 4'b0100;
        do_op(4, idx);
        check("drop_winner", idx, 2);
        req = '0;

        // Randomized operations.
        for (int i = 0; i < 40; i++) begin
            clp_dead = ($urandom_range(7) == 0);
            req = 4'($urandom_range(15));
            if (req == '0) req = 4'b0001;
            for (int r = 0; r < NREQ; r++) begin
                if ($urandom_range(15) == 0)
                    work_time[r*TIME_W +: TIME_W] = 16'(5000 + $urandom_range(59999));
                else
                    work_time[r*TIME_W +: TIME_W] = 16'($urandom_range(63));
            end
            do_op(($urandom_range(3) == 0) ? int'($urandom_range(4, 2)) : -1, idx);
        end
        clp_dead = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
